// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the Select/Enable inputs of a 4:1 MUX.
// It grants one requester at a time and limits each grant to MAX_HOLD cycles.
// It inserts GAP_CYCLES of dead time between grants so Select never moves while Enable is high.
module rr_mux_select_arbiter #(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       Clock_In,
    input  logic       Reset_N_In,
    input  logic [3:0] Request_In,
    output logic [3:0] Grant_Out,
    output logic [1:0] Select_Out,
    output logic       Enable_Out,
    output logic       Busy_Out,
    output logic [3:0] Hold_Count_Out
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
    localparam logic [2:0] GAP_C      = 3'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] gap_q, gap_d;

    logic       any_req;
    logic [1:0] win_idx;
    logic [1:0] scan_idx;
    logic       arb_now;

    // Find the first requester at or above the priority pointer, wrapping modulo 4
    always_comb begin
        any_req  = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!any_req && Request_In[scan_idx]) begin
                any_req = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Next-state and next-output logic. Arbitration happens in IDLE and on the final gap cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        arb_now = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q >= GAP_C));

        if (arb_now) begin
            gap_d = '0;
            if (any_req) begin
                state_d = ST_GRANT;
                grant_d = 4'b0001 << win_idx;
                sel_d   = win_idx;
                en_d    = 1'b1;
                busy_d  = 1'b1;
                hold_d  = 4'd1;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        end else if (state_q == ST_GRANT) begin
            if (Request_In[sel_q] && (hold_q < MAX_HOLD_C)) begin
                hold_d = hold_q + 4'd1;
            end else begin
                state_d = ST_GAP;
                grant_d = '0;
                en_d    = 1'b0;
                busy_d  = 1'b1;
                hold_d  = '0;
                ptr_d   = sel_q + 2'd1;
                gap_d   = 3'd1;
            end
        end else begin
            gap_d = gap_q + 3'd1;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    assign Grant_Out      = grant_q;
    assign Select_Out     = sel_q;
    assign Enable_Out     = en_q;
    assign Busy_Out       = busy_q;
    assign Hold_Count_Out = hold_q;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Bench for rr_mux_select_arbiter: directed scenarios plus random traffic.
// Results are compared against a cycle-level behavioural model.
module tb_rr_mux_select_arbiter;

    localparam int MAX_HOLD   = 8;
    localparam int GAP_CYCLES = 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic [3:0] hold;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current holder (-1 = none), hold count, gap cycles remaining,
    // priority pointer, and the last index driven onto Select.
    int m_cur  = -1;
    int m_hold = 0;
    int m_gap  = 0;
    int m_ptr  = 0;
    int m_sel  = 0;

    rr_mux_select_arbiter #(
        .MAX_HOLD  (MAX_HOLD),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .Clock_In      (clk),
        .Reset_N_In    (rst_n),
        .Request_In    (req),
        .Grant_Out     (grant),
        .Select_Out    (sel),
        .Enable_Out    (en),
        .Busy_Out      (busy),
        .Hold_Count_Out(hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur  = -1;
        m_hold = 0;
        m_gap  = 0;
        m_ptr  = 0;
        m_sel  = 0;
    endtask

    // Advance the model by one rising edge with request vector r sampled
    task automatic model_step(input logic [3:0] r);
        int idx;
        if (m_cur >= 0) begin
            if (r[m_cur] && m_hold < MAX_HOLD) begin
                m_hold++;
            end else begin
                m_ptr  = (m_cur + 1) % 4;
                m_cur  = -1;
                m_hold = 0;
                m_gap  = GAP_CYCLES;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (m_cur < 0 && r[idx]) begin
                    m_cur  = idx;
                    m_hold = 1;
                    m_sel  = idx;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"}, 32'(grant), (m_cur >= 0) ? (1 << m_cur) : 0);
        check({tag, ".sel"},   32'(sel),   m_sel);
        check({tag, ".en"},    32'(en),    (m_cur >= 0) ? 1 : 0);
        check({tag, ".busy"},  32'(busy),  (m_cur >= 0 || m_gap > 0) ? 1 : 0);
        check({tag, ".hold"},  32'(hold),  m_hold);
    endtask

    // Entered and left at a falling edge: drive, take the rising edge, sample 1ns later
    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs clear before any clock edge
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int starts_sel[$];
    int starts_cyc[$];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset");
        rst_n = 1'b1;

        // Async reset in the middle of a grant to requester 1, then 0011 wins 0
        cycle(4'b0010, "t1_g1");
        cycle(4'b0010, "t1_g1b");
        async_reset("t1_rst");
        cycle(4'b0011, "t1_after");
        check("t1_first_is_0", 32'(grant), 1);
        cycle(4'b0000, "t1_rel");
        cycle(4'b0000, "t1_gap");

        // Single request for 3 edges, then the pointer is checked via 1001
        async_reset("t2_rst");
        for (int i = 0; i < 3; i++) cycle(4'b0100, "t2_hold");
        cycle(4'b0000, "t2_rel");
        cycle(4'b0000, "t2_gap");
        cycle(4'b0000, "t2_idle");
        cycle(4'b1001, "t2_ptr");
        check("t2_ptr_grants_3", 32'(grant), 8);
        cycle(4'b0000, "t2_rel2");
        cycle(4'b0000, "t2_gap2");

        // Saturation from pointer 0: record the grant starts
        async_reset("t3_rst");
        for (int c = 0; c < 45; c++) begin
            cycle(4'b1111, "t3_sat");
            if (en && hold == 4'd1) begin
                starts_sel.push_back(int'(sel));
                starts_cyc.push_back(c);
            end
        end
        check("t3_starts", starts_sel.size(), 5);
        for (int i = 0; i < 5 && i < starts_sel.size(); i++) begin
            check("t3_order", starts_sel[i], i % 4);
            if (i > 0) check("t3_period", starts_cyc[i] - starts_cyc[i-1], MAX_HOLD + GAP_CYCLES);
        end
        cycle(4'b0000, "t3_drain");
        cycle(4'b0000, "t3_drain");

        // One-cycle pulse on requester 1
        async_reset("t4_rst");
        cycle(4'b0010, "t4_pulse");
        for (int i = 0; i < 4; i++) cycle(4'b0000, "t4_after");
        check("t4_sel_kept", 32'(sel), 1);

        // No preemption while requester 2 holds
        async_reset("t5_rst");
        cycle(4'b0100, "t5_g2");
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0101, "t5_nopre");
            check("t5_still_2", 32'(grant), 4);
        end
        cycle(4'b0001, "t5_rel");
        cycle(4'b0001, "t5_gap_arb");
        check("t5_wrap_to_0", 32'(grant), 1);
        cycle(4'b0000, "t5_rel2");
        cycle(4'b0000, "t5_gap2");

        // Lone hog on requester 0 for 20 cycles
        async_reset("t6_rst");
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0001, "t6_hog");
            check("t6_hold_le_max", (int'(hold) <= MAX_HOLD) ? 1 : 0, 1);
        end
        cycle(4'b0000, "t6_rel");
        cycle(4'b0000, "t6_gap");

        // Random traffic with sticky requests and an occasional mid-run reset
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            else r = req | 4'($urandom_range(0, 1) << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) r = r & 4'($urandom);
            if (n % 997 == 500) async_reset("rnd_rst");
            cycle(r, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
